// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, one-cycle-latency memory between
// instruction fetch and the data stage. Data wins by default; a starvation
// counter forces a fetch grant after MAX_WAIT consecutive denied fetch cycles.
module mem_port_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_data,
  input  logic          d_req,
  input  logic          d_wen,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [1:0] {
    NONE,
    RET_IF,
    RET_DR,
    RET_DW
  } ret_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  ret_t       ret;
  logic [3:0] wait_cnt;
  logic       fetch_pri;

  // Grant decision and memory port mux; idle cycles read if_addr harmlessly
  always_comb begin
    fetch_pri = (wait_cnt == MAX_W);
    d_gnt     = d_req & ~(fetch_pri & if_req);
    if_gnt    = if_req & ~d_gnt;
    stall_if  = if_req & ~if_gnt;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wen   = d_wen;
      mem_wdata = d_wdata;
    end else begin
      mem_addr  = if_addr;
      mem_wen   = 1'b0;
      mem_wdata = '0;
    end
  end

  // Return tracking, fetch starvation counter and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ret       <= NONE;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (if_gnt)
        ret <= RET_IF;
      else if (d_gnt && !d_wen)
        ret <= RET_DR;
      else if (d_gnt && d_wen)
        ret <= RET_DW;
      else
        ret <= NONE;

      if (if_gnt || !if_req)
        wait_cnt <= '0;
      else if (wait_cnt != MAX_W)
        wait_cnt <= wait_cnt + 4'd1;

      if (stall_if && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Response routing; reset masks a response still in flight from the prior grant
  always_comb begin
    if_valid = (ret == RET_IF) & ~rst;
    d_valid  = ((ret == RET_DR) | (ret == RET_DW)) & ~rst;
    if_data  = ((ret == RET_IF) && !rst) ? mem_rdata : '0;
    d_rdata  = ((ret == RET_DR) && !rst) ? mem_rdata : '0;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, one-cycle-read-latency `memory` instance between the instruction-fetch stage and the data (MEM) stage of the pipelined core. At most one access is issued to the memory per cycle. Each access's read data or write completion is routed back to its owner exactly one cycle later. Data accesses win by default; a starvation counter guarantees fetch progress, and a stall counter exposes fetch-stall cycles for performance measurement.

## Interface
Parameters:
- `AW`, 16, memory address width
- `DW`, 16, memory data width
- `MAX_WAIT`, 4, consecutive denied fetch cycles before fetch takes priority (1..15)

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request; held until granted
- `if_addr`  in  AW  fetch address
- `if_gnt`  out  1  fetch access issued this cycle (combinational)
- `if_valid`  out  1  fetch data valid (registered)
- `if_data`  out  DW  fetch data; 0 when `if_valid`=0
- `d_req`  in  1  data request; held until granted
- `d_wen`  in  1  1 = store, 0 = load
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_gnt`  out  1  data access issued this cycle (combinational)
- `d_valid`  out  1  load data valid, or store complete (registered)
- `d_rdata`  out  DW  load data; 0 unless `d_valid` is set and the access was a load
- `mem_wen`  out  1  to memory `wen`
- `mem_addr`  out  AW  to memory `addr`
- `mem_wdata`  out  DW  to memory `data_in`
- `mem_rdata`  in  DW  from memory `data_out`; one cycle after the address
- `stall_if`  out  1  `if_req` & ~`if_gnt`
- `stall_cnt`  out  16  saturating count of `stall_if` cycles

## Operation
- Grant decision, combinational each cycle:
  - `fetch_pri` = (`wait_cnt` == `MAX_WAIT`).
  - `d_gnt` = `d_req` & ~(`fetch_pri` & `if_req`).
  - `if_gnt` = `if_req` & ~`d_gnt`.
  - `if_gnt` and `d_gnt` are never both 1.
- Memory mux:
  - `d_gnt`: addr = `d_addr`, wen = `d_wen`, wdata = `d_wdata`.
  - otherwise: addr = `if_addr`, wen = 0, wdata = 0. An idle cycle is a harmless read of `if_addr`.
- Return-tracking FSM `ret`:
  - States: NONE, RET_IF, RET_DR (data read), RET_DW (data write).
  - Next state = RET_IF if `if_gnt`; RET_DR if `d_gnt`&~`d_wen`; RET_DW if `d_gnt`&`d_wen`; else NONE.
- Outputs from the FSM:
  - `if_valid` = (`ret`==RET_IF).
  - `d_valid` = (`ret`==RET_DR or RET_DW).
  - `if_data` = `mem_rdata` in RET_IF, else 0.
  - `d_rdata` = `mem_rdata` in RET_DR, else 0.
- `wait_cnt`, width 4:
  - Cleared when `if_gnt` or ~`if_req`.
  - Otherwise increments, saturating at `MAX_WAIT`.
- `stall_cnt`: increments when `stall_if`=1; holds at 16'hFFFF.

## Timing
- Grant: zero latency, same cycle as the request, when that request wins.
- Response: `if_valid`/`d_valid` is a one-cycle pulse in cycle t+1 for a grant in cycle t.
- Throughput: one access per cycle, back-to-back with no bubbles; alternating owners is allowed.
- Request rule: requester keeps req/addr/wdata stable until it sees its grant. Deasserting before grant is legal; that request is dropped.
- Simultaneous `if_req`&`d_req`:
  - `wait_cnt` < `MAX_WAIT`: data wins.
  - `wait_cnt` == `MAX_WAIT`: fetch wins, `wait_cnt` clears, and data stalls one cycle.
- Continuous `d_req` with continuous `if_req`: fetch is granted exactly once every `MAX_WAIT`+1 cycles.
- Reset values: `ret`=NONE, `wait_cnt`=0, `stall_cnt`=0, so `if_valid`=`d_valid`=0 and `if_data`=`d_rdata`=0.
- Grant outputs during reset:
  - `if_gnt`/`d_gnt`/`mem_wen` remain combinational functions of the requests.
  - The core must hold requests low during `rst`.
- Reset asserted in the cycle after a grant: the pending response is discarded, with no valid pulse after reset deasserts.

## Test plan
- Fetch only:
  - Stimulus: `if_req`=1 with addresses 0,1,2 over 3 cycles; memory preloaded with 16'h1234, 16'h5678, 16'h9ABC.
  - Required: `if_gnt`=1 each cycle; `if_valid` in cycles 2..4 carrying those words; `stall_cnt`=0.
- Store then load:
  - Stimulus: `d_req`=1, `d_wen`=1, addr 16'h0040, data 16'hBEEF; next cycle a load from 16'h0040.
  - Required: `d_valid` pulse after each; the load returns `d_rdata`=16'hBEEF; `mem_wen` high only in the store cycle.
- Contention with MAX_WAIT=4:
  - Stimulus: `if_req` and `d_req` held high for 10 cycles.
  - Required: grant pattern D,D,D,D,I,D,D,D,D,I; `stall_cnt`=8.
- Simultaneous returns:
  - Stimulus: alternate D and I grants every cycle.
  - Required: `if_valid` and `d_valid` never high together; each data word reaches the correct owner.
- Reset mid-operation:
  - Stimulus: grant a load in cycle t; assert `rst` in t+1.
  - Required: `d_valid`=0 in t+1 and after; `wait_cnt` and `stall_cnt` read 0.
- Stall counter saturation:
  - Stimulus: force 70000 stall cycles.
  - Required: `stall_cnt` stays at 16'hFFFF with no wrap to 0.
